// File: rtl/axi_param_loader.sv
// Loads packed weight and bias elements from memory over an AXI4-Lite read
// channel into two local memories, one read in flight at a time.
module axi_param_loader #(
    parameter int unsigned W_COUNT = 756,
    parameter int unsigned B_COUNT = 28,
    parameter int unsigned ELEM_W  = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               start,
    input  logic [31:0]                                        base_addr,
    output logic                                               busy,
    output logic                                               done,
    output logic                                               error,
    output logic                                               loaded,
    output logic                                               M_AXI_ARVALID,
    input  logic                                               M_AXI_ARREADY,
    output logic [31:0]                                        M_AXI_ARADDR,
    output logic [2:0]                                         M_AXI_ARPROT,
    input  logic                                               M_AXI_RVALID,
    output logic                                               M_AXI_RREADY,
    input  logic [31:0]                                        M_AXI_RDATA,
    input  logic [1:0]                                         M_AXI_RRESP,
    input  logic [((W_COUNT > 1) ? $clog2(W_COUNT) : 1)-1:0]   w_rd_addr,
    output logic [ELEM_W-1:0]                                  w_rd_data,
    input  logic [((B_COUNT > 1) ? $clog2(B_COUNT) : 1)-1:0]   b_rd_addr,
    output logic [ELEM_W-1:0]                                  b_rd_data
);

    localparam int unsigned W_AW   = (W_COUNT > 1) ? $clog2(W_COUNT) : 1;
    localparam int unsigned B_AW   = (B_COUNT > 1) ? $clog2(B_COUNT) : 1;
    localparam int unsigned PACK   = 32 / ELEM_W;
    localparam int unsigned WB     = (W_COUNT + PACK - 1) / PACK;
    localparam int unsigned BB     = (B_COUNT + PACK - 1) / PACK;
    localparam int unsigned MAXB   = (WB > BB) ? WB : BB;
    localparam int unsigned CNT_W  = $clog2(MAXB + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ERR} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic               region_bias;
    logic               accept;
    logic               r_hs;
    logic               beat_ok;
    logic               last_w;
    logic               last_b;
    logic [31:0]        lane_idx [PACK];

    logic [ELEM_W-1:0]  w_mem [W_COUNT];
    logic [ELEM_W-1:0]  b_mem [B_COUNT];

    assign M_AXI_ARPROT = 3'b000;

    assign accept  = (state == IDLE) && start;
    assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;
    assign beat_ok = r_hs && (M_AXI_RRESP == 2'b00);
    assign last_w  = !region_bias && (beat_cnt == CNT_W'(WB - 1));
    assign last_b  = region_bias && (beat_cnt == CNT_W'(BB - 1));

    // Element index targeted by each lane of the current beat
    for (genvar g = 0; g < PACK; g++) begin : g_lane
        assign lane_idx[g] = 32'(beat_cnt) * PACK + 32'(g);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ADDR;
            ADDR: if (M_AXI_ARVALID && M_AXI_ARREADY) state_nxt = DATA;
            DATA: begin
                if (r_hs) begin
                    if (M_AXI_RRESP != 2'b00) state_nxt = ERR;
                    else if (last_b)          state_nxt = DONE;
                    else                      state_nxt = ADDR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, address and beat bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            loaded        <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_ARADDR  <= 32'h0;
            beat_cnt      <= '0;
            region_bias   <= 1'b0;
        end else begin
            busy          <= (state_nxt == ADDR) || (state_nxt == DATA);
            done          <= (state_nxt == DONE) || (state_nxt == ERR);
            M_AXI_ARVALID <= (state_nxt == ADDR);
            M_AXI_RREADY  <= (state_nxt == DATA);
            if (accept) begin
                M_AXI_ARADDR <= base_addr;
                beat_cnt     <= '0;
                region_bias  <= 1'b0;
                error        <= 1'b0;
                loaded       <= 1'b0;
            end else if (beat_ok) begin
                // Bias region sits directly after the weights, so the address just increments
                M_AXI_ARADDR <= M_AXI_ARADDR + 32'd4;
                if (last_w) begin
                    region_bias <= 1'b1;
                    beat_cnt    <= '0;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
            if (state_nxt == DONE) loaded <= 1'b1;
            if (state_nxt == ERR) begin
                error  <= 1'b1;
                loaded <= 1'b0;
            end
        end
    end

    // Unpack an accepted beat; lanes past the element count are dropped
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(PACK); i++) begin
            if (beat_ok && !region_bias && (lane_idx[i] < W_COUNT))
                w_mem[W_AW'(lane_idx[i])] <= M_AXI_RDATA[i*ELEM_W +: ELEM_W];
            if (beat_ok && region_bias && (lane_idx[i] < B_COUNT))
                b_mem[B_AW'(lane_idx[i])] <= M_AXI_RDATA[i*ELEM_W +: ELEM_W];
        end
    end

    // Registered read ports, zero outside the element range
    always_ff @(posedge clk) begin
        w_rd_data <= (32'(w_rd_addr) < W_COUNT) ? w_mem[w_rd_addr] : '0;
        b_rd_data <= (32'(b_rd_addr) < B_COUNT) ? b_mem[b_rd_addr] : '0;
    end

endmodule

// File: tb/tb_axi_param_loader.sv
// Directed bench for axi_param_loader: an 8-bit config with a delay-capable
// read slave, and a 16-bit config with an always-ready slave.
module tb_axi_param_loader;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: W=10, B=3, ELEM_W=8 ----------------
    logic        a_start;
    logic [31:0] a_base;
    logic        a_busy, a_done, a_error, a_loaded;
    logic        a_arvalid, a_arready, a_rvalid, a_rready;
    logic [31:0] a_araddr, a_rdata;
    logic [2:0]  a_arprot;
    logic [1:0]  a_rresp;
    logic [3:0]  a_w_addr;
    logic [7:0]  a_w_data;
    logic [1:0]  a_b_addr;
    logic [7:0]  a_b_data;

    axi_param_loader #(.W_COUNT(10), .B_COUNT(3), .ELEM_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(a_base),
        .busy(a_busy), .done(a_done), .error(a_error), .loaded(a_loaded),
        .M_AXI_ARVALID(a_arvalid), .M_AXI_ARREADY(a_arready),
        .M_AXI_ARADDR(a_araddr), .M_AXI_ARPROT(a_arprot),
        .M_AXI_RVALID(a_rvalid), .M_AXI_RREADY(a_rready),
        .M_AXI_RDATA(a_rdata), .M_AXI_RRESP(a_rresp),
        .w_rd_addr(a_w_addr), .w_rd_data(a_w_data),
        .b_rd_addr(a_b_addr), .b_rd_data(a_b_data)
    );

    // Slave A: word table at 0x1000, programmable handshake delays and error address
    logic [31:0] words [4];
    logic [31:0] xor_mask;
    logic [31:0] err_addr;
    int          ar_dly, r_dly, ar_cnt, r_cnt;
    logic        pend;
    logic [31:0] pend_addr, widx;
    logic [31:0] ar_log [64];
    int          ar_n = 0;

    assign a_arready = a_arvalid && (ar_cnt >= ar_dly);
    assign a_rvalid  = pend && (r_cnt >= r_dly);
    assign widx      = (pend_addr - 32'h1000) >> 2;
    assign a_rdata   = (widx < 4) ? (words[widx[1:0]] ^ xor_mask) : 32'h0;
    assign a_rresp   = (pend && pend_addr == err_addr) ? 2'b10 : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt <= 0; r_cnt <= 0; pend <= 1'b0; pend_addr <= 32'h0;
        end else begin
            if (a_arvalid && a_arready) begin
                ar_cnt <= 0; pend <= 1'b1; pend_addr <= a_araddr; r_cnt <= 0;
                ar_log[ar_n[5:0]] <= a_araddr; ar_n <= ar_n + 1;
            end else if (a_arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (a_rvalid && a_rready) pend <= 1'b0;
            else if (pend && !a_rvalid) r_cnt <= r_cnt + 1;
        end
    end

    // Protocol monitor: ARVALID/ARADDR held while stalled, no AR/R overlap
    int          stab_err = 0;
    int          ovl_err  = 0;
    logic        hold_prev;
    logic [31:0] prev_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_prev <= 1'b0; prev_addr <= 32'h0;
        end else begin
            if (hold_prev && (!a_arvalid || a_araddr != prev_addr)) stab_err <= stab_err + 1;
            if (a_arvalid && a_rready) ovl_err <= ovl_err + 1;
            hold_prev <= a_arvalid && !a_arready;
            prev_addr <= a_araddr;
        end
    end

    // ---------------- DUT B: W=3, B=1, ELEM_W=16 ----------------
    logic        b_start;
    logic [31:0] b_base;
    logic        b_busy, b_done, b_error, b_loaded;
    logic        b_arvalid, b_arready, b_rvalid, b_rready;
    logic [31:0] b_araddr, b_rdata;
    logic [2:0]  b_arprot;
    logic [1:0]  b_rresp;
    logic [1:0]  b_w_addr;
    logic [15:0] b_w_data;
    logic [0:0]  b_b_addr;
    logic [15:0] b_b_data;

    axi_param_loader #(.W_COUNT(3), .B_COUNT(1), .ELEM_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base),
        .busy(b_busy), .done(b_done), .error(b_error), .loaded(b_loaded),
        .M_AXI_ARVALID(b_arvalid), .M_AXI_ARREADY(b_arready),
        .M_AXI_ARADDR(b_araddr), .M_AXI_ARPROT(b_arprot),
        .M_AXI_RVALID(b_rvalid), .M_AXI_RREADY(b_rready),
        .M_AXI_RDATA(b_rdata), .M_AXI_RRESP(b_rresp),
        .w_rd_addr(b_w_addr), .w_rd_data(b_w_data),
        .b_rd_addr(b_b_addr), .b_rd_data(b_b_data)
    );

    logic        bpend;
    logic [31:0] bpa;
    logic [31:0] b_last_ar;
    int          b_ar_n = 0;

    assign b_arready = 1'b1;
    assign b_rvalid  = bpend;
    assign b_rresp   = 2'b00;
    assign b_rdata   = (bpa == 32'h2000) ? 32'h1111_2222 :
                       (bpa == 32'h2004) ? 32'hBEEF_8001 :
                       (bpa == 32'h2008) ? 32'hCAFE_7FFE : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpend <= 1'b0; bpa <= 32'h0; b_last_ar <= 32'h0;
        end else begin
            if (b_arvalid && b_arready) begin
                bpend <= 1'b1; bpa <= b_araddr; b_last_ar <= b_araddr; b_ar_n <= b_ar_n + 1;
            end
            if (b_rvalid && b_rready) bpend <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] exp_w [10];
    logic [7:0] exp_b [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_aw(input int idx, input logic [7:0] e, input string tag);
        a_w_addr = 4'(idx);
        @(posedge clk); #1;
        chk($sformatf("%s_w%0d", tag, idx), 32'(a_w_data), 32'(e));
    endtask

    task automatic rd_ab(input int idx, input logic [7:0] e, input string tag);
        a_b_addr = 2'(idx);
        @(posedge clk); #1;
        chk($sformatf("%s_b%0d", tag, idx), 32'(a_b_data), 32'(e));
    endtask

    task automatic check_all_a(input string tag);
        for (int i = 0; i < 10; i++) rd_aw(i, exp_w[i], tag);
        for (int i = 0; i < 3; i++)  rd_ab(i, exp_b[i], tag);
        @(negedge clk);
    endtask

    // Pulse start for one cycle and wait (bounded) for done; cyc counts negedges
    task automatic run_a(input int budget, output int cyc);
        @(negedge clk);
        a_start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) a_start = 1'b0;
        end while (!a_done && cyc < budget);
        chk("a_done_seen", 32'(a_done), 32'd1);
    endtask

    task automatic wait_done_a(input int budget);
        int cyc = 0;
        while (!a_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("a_done_wait", 32'(a_done), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int base;
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_base = 32'h1000; b_base = 32'h2000;
        a_w_addr = '0; a_b_addr = '0; b_w_addr = '0; b_b_addr = '0;
        words[0] = 32'h8403_0201; words[1] = 32'h0807_06F5;
        words[2] = 32'hDEAD_7F90; words[3] = 32'h5566_A1B2;
        xor_mask = 32'h0; err_addr = 32'hFFFF_FFFF; ar_dly = 0; r_dly = 0;
        exp_w[0] = 8'h01; exp_w[1] = 8'h02; exp_w[2] = 8'h03; exp_w[3] = 8'h84;
        exp_w[4] = 8'hF5; exp_w[5] = 8'h06; exp_w[6] = 8'h07; exp_w[7] = 8'h08;
        exp_w[8] = 8'h90; exp_w[9] = 8'h7F;
        exp_b[0] = 8'hB2; exp_b[1] = 8'hA1; exp_b[2] = 8'h66;

        repeat (3) @(negedge clk);
        chk("rst_busy",    32'(a_busy), 0);
        chk("rst_done",    32'(a_done), 0);
        chk("rst_error",   32'(a_error), 0);
        chk("rst_loaded",  32'(a_loaded), 0);
        chk("rst_arvalid", 32'(a_arvalid), 0);
        chk("rst_rready",  32'(a_rready), 0);
        chk("rst_araddr",  a_araddr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load, ready slave
        base = ar_n;
        run_a(200, cyc);
        chk("t1_latency", 32'(cyc), 32'd9);
        chk("t1_loaded",  32'(a_loaded), 1);
        chk("t1_error",   32'(a_error), 0);
        chk("t1_busy",    32'(a_busy), 0);
        chk("t1_arprot",  32'(a_arprot), 0);
        chk("t1_ar_n",    32'(ar_n - base), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_araddr%0d", i), ar_log[base + i], 32'h1000 + 32'(4 * i));
        @(negedge clk);
        chk("t1_done_pulse", 32'(a_done), 0);
        chk("t1_loaded_hold", 32'(a_loaded), 1);
        check_all_a("t1");
        rd_aw(12, 8'h00, "t1_oor");
        rd_ab(3, 8'h00, "t1_oor");

        // Error on beat 1: beat 0 stored inverted, beats 1.. untouched
        xor_mask = 32'hFFFF_FFFF; err_addr = 32'h1004;
        base = ar_n;
        run_a(200, cyc);
        chk("t3_error",  32'(a_error), 1);
        chk("t3_loaded", 32'(a_loaded), 0);
        chk("t3_busy",   32'(a_busy), 0);
        chk("t3_ar_n",   32'(ar_n - base), 2);
        repeat (3) @(negedge clk);
        chk("t3_error_sticky", 32'(a_error), 1);
        chk("t3_done_low",     32'(a_done), 0);
        rd_aw(0, 8'hFE, "t3");
        for (int i = 4; i < 8; i++) rd_aw(i, exp_w[i], "t3");
        @(negedge clk);

        // Stalled slave: AR held 3 cycles, R delayed 2 cycles
        xor_mask = 32'h0; err_addr = 32'hFFFF_FFFF; ar_dly = 3; r_dly = 2;
        base = ar_n;
        run_a(400, cyc);
        chk("t2_loaded", 32'(a_loaded), 1);
        chk("t2_error",  32'(a_error), 0);
        chk("t2_ar_n",   32'(ar_n - base), 4);
        chk("t2_slow",   32'(cyc > 9), 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_araddr%0d", i), ar_log[base + i], 32'h1000 + 32'(4 * i));
        check_all_a("t2");
        ar_dly = 0; r_dly = 0;

        // Reset during third weight beat, then reload
        words[0] = 32'h1122_3344;
        exp_w[0] = 8'h44; exp_w[1] = 8'h33; exp_w[2] = 8'h22; exp_w[3] = 8'h11;
        base = ar_n;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 0;
        while ((ar_n - base) < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_third_beat", 32'(ar_n - base), 3);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy",    32'(a_busy), 0);
        chk("t4_rst_loaded",  32'(a_loaded), 0);
        chk("t4_rst_arvalid", 32'(a_arvalid), 0);
        chk("t4_rst_rready",  32'(a_rready), 0);
        chk("t4_rst_araddr",  a_araddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_loaded_low", 32'(a_loaded), 0);
        base = ar_n;
        run_a(200, cyc);
        chk("t4_loaded", 32'(a_loaded), 1);
        chk("t4_ar_n",   32'(ar_n - base), 4);
        chk("t4_first_ar", ar_log[base], 32'h1000);
        check_all_a("t4");

        // start held through a load with a mid-load pulse: one load only
        base = ar_n;
        @(negedge clk);
        a_start = 1'b1;
        repeat (2) @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        a_start = 1'b1;
        wait_done_a(200);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_one_load", 32'(ar_n - base), 4);
        chk("t5_idle",     32'(a_busy), 0);

        // start still high at IDLE re-entry: next load starts
        base = ar_n;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        wait_done_a(200);
        @(negedge clk);
        chk("t5_reentry_idle", 32'(a_busy), 0);
        @(negedge clk);
        chk("t5_restart_busy", 32'(a_busy), 1);
        a_start = 1'b0;
        wait_done_a(200);
        chk("t5_two_loads", 32'(ar_n - base), 8);

        // 16-bit elements on DUT B
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 0;
        while (!b_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_done",    32'(b_done), 1);
        chk("t6_loaded",  32'(b_loaded), 1);
        chk("t6_ar_n",    32'(b_ar_n), 3);
        chk("t6_bias_ar", b_last_ar, 32'h2008);
        b_w_addr = 2'd0; @(posedge clk); #1; chk("t6_w0", 32'(b_w_data), 32'h2222);
        b_w_addr = 2'd1; @(posedge clk); #1; chk("t6_w1", 32'(b_w_data), 32'h1111);
        b_w_addr = 2'd2; @(posedge clk); #1; chk("t6_w2", 32'(b_w_data), 32'h8001);
        b_w_addr = 2'd3; @(posedge clk); #1; chk("t6_w3_oor", 32'(b_w_data), 32'h0);
        b_b_addr = 1'b0; @(posedge clk); #1; chk("t6_b0", 32'(b_b_data), 32'h7FFE);
        b_b_addr = 1'b1; @(posedge clk); #1; chk("t6_b1_oor", 32'(b_b_data), 32'h0);

        @(negedge clk);
        chk("ar_stable",    32'(stab_err), 0);
        chk("ar_r_overlap", 32'(ovl_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
